// File: rtl/storage_bank.sv
// DEPTH-entry circular switch store with FIFO pop / direct peek, driven by edge-detected keys.
// Optional key debounce filter enabled by defining STORAGE_BANK_DEBOUNCE_EN.
module storage_bank #(
   parameter int WIDTH           = 8,
   parameter int DEPTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      key1_record,
   input  logic                      key2_transfer,
   input  logic [WIDTH-1:0]          sw,
   input  logic                      sw8,
   output logic [$clog2(DEPTH)+4:0]  ledr,
   output logic [WIDTH-1:0]          ledg,
   output logic [6:0]                hex0,
   output logic [6:0]                hex1,
   output logic [6:0]                hex2,
   output logic [6:0]                hex3
);

   localparam int ADDR_W     = $clog2(DEPTH);
   localparam int CNT_W      = ADDR_W + 1;
   localparam int NUM_DIGITS = WIDTH / 4;

   logic [1:0]        sync1_q;
   logic [1:0]        sync2_q;
   logic [1:0]        prev_q;
   logic [1:0]        filtKey;
   logic [1:0]        pulse;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wrPtr_q;
   logic [ADDR_W-1:0] rdPtr_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;
   logic              overflow_q;
   logic              underflow_q;
   logic [WIDTH-1:0]  ledg_q;

   logic              full;
   logic              empty;
   logic              popReq;
   logic              peekReq;
   logic              doPop;
   logic              doWrite;

   // Bit 0 carries the record key, bit 1 the transfer key.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
         prev_q  <= 2'b00;
      end else begin
         sync1_q <= {key2_transfer, key1_record};
         sync2_q <= sync1_q;
         prev_q  <= filtKey;
      end
   end

`ifdef STORAGE_BANK_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [DB_W-1:0] dbCnt_q [2];
   logic [1:0]      dbHigh_q;

   // dbHigh_q resets low so a key held through reset never looks like a fresh press.
   always_ff @(posedge clk) begin
      if (rst) begin
         dbHigh_q <= 2'b00;
         for (int k = 0; k < 2; k++) dbCnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (sync2_q[k]) begin
               dbHigh_q[k] <= 1'b1;
               dbCnt_q[k]  <= '0;
            end else if (dbHigh_q[k]) begin
               if (dbCnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                  dbHigh_q[k] <= 1'b0;
                  dbCnt_q[k]  <= '0;
               end else begin
                  dbCnt_q[k] <= dbCnt_q[k] + 1'b1;
               end
            end
         end
      end
   end

   assign filtKey = sync2_q | dbHigh_q;
`else
   assign filtKey = sync2_q;
`endif

   assign pulse = prev_q & ~filtKey;

   // A pop frees a slot in the same cycle, so a record into a full store still succeeds then.
   always_comb begin
      full    = (count_q == CNT_W'(DEPTH));
      empty   = (count_q == '0);
      popReq  = pulse[1] & ~sw8;
      peekReq = pulse[1] & sw8;
      doPop   = popReq & ~empty;
      doWrite = pulse[0] & (~full | doPop);
      count_d = count_q + CNT_W'(doWrite) - CNT_W'(doPop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         ledg_q      <= '0;
      end else begin
         if (doWrite) begin
            mem_q[wrPtr_q] <= sw;
            wrPtr_q        <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            ledg_q  <= mem_q[rdPtr_q];
            rdPtr_q <= rdPtr_q + 1'b1;
         end else if (peekReq) begin
            ledg_q <= mem_q[sw[ADDR_W-1:0]];
         end
         if (pulse[0] && full && !doPop) overflow_q <= 1'b1;
         if (popReq && empty) underflow_q <= 1'b1;
         count_q <= count_d;
      end
   end

   function automatic logic [6:0] hexGlyph(input logic [3:0] n);
      case (n)
         4'h0: hexGlyph = 7'h40;
         4'h1: hexGlyph = 7'h79;
         4'h2: hexGlyph = 7'h24;
         4'h3: hexGlyph = 7'h30;
         4'h4: hexGlyph = 7'h19;
         4'h5: hexGlyph = 7'h12;
         4'h6: hexGlyph = 7'h02;
         4'h7: hexGlyph = 7'h78;
         4'h8: hexGlyph = 7'h00;
         4'h9: hexGlyph = 7'h10;
         4'hA: hexGlyph = 7'h08;
         4'hB: hexGlyph = 7'h03;
         4'hC: hexGlyph = 7'h46;
         4'hD: hexGlyph = 7'h21;
         4'hE: hexGlyph = 7'h06;
         default: hexGlyph = 7'h0E;
      endcase
   endfunction

   logic [15:0] ledgPad;
   assign ledgPad = 16'(ledg_q);

   assign ledg = ledg_q;
   assign ledr = {overflow_q, underflow_q, full, empty, count_q};
   assign hex0 = hexGlyph(ledgPad[3:0]);
   assign hex1 = (NUM_DIGITS > 1) ? hexGlyph(ledgPad[7:4])   : 7'h7F;
   assign hex2 = (NUM_DIGITS > 2) ? hexGlyph(ledgPad[11:8])  : 7'h7F;
   assign hex3 = (NUM_DIGITS > 3) ? hexGlyph(ledgPad[15:12]) : 7'h7F;

endmodule

// File: tb/tb_storage_bank.sv
// Bench for storage_bank (WIDTH=8, DEPTH=8): directed and random key presses against a queue model.
module tb_storage_bank;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int DBC   = 16;
`ifdef STORAGE_BANK_DEBOUNCE_EN
   localparam int PRESS_CYC = 3 + DBC;
`else
   localparam int PRESS_CYC = 3;
`endif

   localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             key1 = 1'b1;
   logic             key2 = 1'b1;
   logic [WIDTH-1:0] sw = '0;
   logic             sw8 = 1'b0;
   logic [7:0]       ledr;
   logic [WIDTH-1:0] ledg;
   logic [6:0]       hex0, hex1, hex2, hex3;

   int nCompared = 0;
   int nMismatch = 0;

   logic [7:0] modelMem [DEPTH];
   logic [7:0] modelQ [$];
   int         writes;
   bit         expOvf;
   bit         expUnf;
   logic [7:0] expLedg;

   storage_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DBC)) dut (
      .clk(clk), .rst(rst), .key1_record(key1), .key2_transfer(key2),
      .sw(sw), .sw8(sw8), .ledr(ledr), .ledg(ledg),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      for (int i = 0; i < DEPTH; i++) modelMem[i] = 8'h00;
      modelQ.delete();
      writes  = 0;
      expOvf  = 1'b0;
      expUnf  = 1'b0;
      expLedg = 8'h00;
   endtask

   // Reads see the store as it was before this action's write.
   task automatic modelStep(input bit rec, input bit xfer, input logic [7:0] swV, input bit s8);
      bit popped;
      popped = 1'b0;
      if (xfer && !s8) begin
         if (modelQ.size() == 0) expUnf = 1'b1;
         else begin
            expLedg = modelQ.pop_front();
            popped  = 1'b1;
         end
      end
      if (xfer && s8) expLedg = modelMem[swV % DEPTH];
      if (rec) begin
         if (modelQ.size() == DEPTH && !popped) expOvf = 1'b1;
         else begin
            modelMem[writes % DEPTH] = swV;
            writes++;
            modelQ.push_back(swV);
         end
      end
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      modelReset();
      repeat (5) @(negedge clk);
   endtask

   task automatic applyStimulus(input bit rec, input bit xfer, input logic [7:0] swV, input bit s8);
      @(negedge clk);
      sw   = swV;
      sw8  = s8;
      key1 = ~rec;
      key2 = ~xfer;
      repeat (PRESS_CYC) @(negedge clk);
      key1 = 1'b1;
      key2 = 1'b1;
      repeat (4) @(negedge clk);
      modelStep(rec, xfer, swV, s8);
   endtask

   task automatic checkOutput(input string tag);
      logic [7:0] expLedr;
      int         n;
      n       = modelQ.size();
      expLedr = {expOvf, expUnf, n == DEPTH, n == 0, 4'(n)};
      nCompared++;
      assert (ledg === expLedg) else begin
         nMismatch++;
         $error("FAIL %s ledg observed %h expected %h", tag, ledg, expLedg);
      end
      nCompared++;
      assert (ledr === expLedr) else begin
         nMismatch++;
         $error("FAIL %s ledr observed %b expected %b", tag, ledr, expLedr);
      end
      nCompared++;
      assert (hex0 === GLYPH[expLedg[3:0]]) else begin
         nMismatch++;
         $error("FAIL %s hex0 observed %h expected %h", tag, hex0, GLYPH[expLedg[3:0]]);
      end
      nCompared++;
      assert (hex1 === GLYPH[expLedg[7:4]]) else begin
         nMismatch++;
         $error("FAIL %s hex1 observed %h expected %h", tag, hex1, GLYPH[expLedg[7:4]]);
      end
      nCompared++;
      assert (hex2 === 7'h7F && hex3 === 7'h7F) else begin
         nMismatch++;
         $error("FAIL %s hex2/hex3 observed %h/%h expected 7f/7f", tag, hex2, hex3);
      end
   endtask

   initial begin
      modelReset();
      applyReset();
      checkOutput("reset");

      applyStimulus(1, 0, 8'h06, 0);
      checkOutput("rec06");
      applyStimulus(0, 1, 8'h00, 0);
      checkOutput("pop06");
      applyStimulus(0, 1, 8'h00, 0);
      checkOutput("popEmpty");

      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 8'(8'h11 + i), 0);
      checkOutput("fill");
      applyStimulus(1, 0, 8'h99, 0);
      checkOutput("overflow");
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(0, 1, 8'h00, 0);
         checkOutput($sformatf("drain%0d", i));
      end

      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 8'(8'h31 + i), 0);
      applyStimulus(1, 1, 8'h5A, 0);
      checkOutput("recPop");
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 8'(8'h41 + i), 0);
      applyStimulus(1, 1, 8'h77, 0);
      checkOutput("recPopFull");

      // Reset arrives while the record key is held; only a fresh press may record.
      @(negedge clk);
      sw   = 8'h3C;
      key1 = 1'b0;
      rst  = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      modelReset();
      repeat (PRESS_CYC + 5) @(negedge clk);
      checkOutput("heldThroughReset");
      key1 = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("releasedAfterReset");
      applyStimulus(1, 0, 8'h3C, 0);
      checkOutput("repress");

      applyReset();
      applyStimulus(1, 0, 8'hA0, 0);
      applyStimulus(1, 0, 8'hB0, 0);
      applyStimulus(1, 0, 8'hC0, 0);
      applyStimulus(0, 1, 8'h02, 1);
      checkOutput("peek2");
      applyStimulus(0, 1, 8'h07, 1);
      checkOutput("peek7");
      applyStimulus(0, 1, 8'h00, 1);
      checkOutput("peek0");
      applyStimulus(1, 1, 8'hE3, 1);
      checkOutput("recPeekSameAddr");
      applyStimulus(0, 1, 8'h03, 1);
      checkOutput("peekAfterWrite");

`ifdef STORAGE_BANK_DEBOUNCE_EN
      @(negedge clk);
      key1 = 1'b0;
      repeat (5) @(negedge clk);
      key1 = 1'b1;
      repeat (DBC + 5) @(negedge clk);
      checkOutput("glitch");
`endif

      for (int i = 0; i < 60; i++) begin
         bit         r, x, m;
         logic [7:0] v;
         r = 1'($urandom_range(0, 1));
         x = 1'($urandom_range(0, 1));
         m = ($urandom_range(0, 3) == 0);
         v = 8'($urandom);
         applyStimulus(r, x, v, m);
         checkOutput($sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
